// File: rtl/step_run_ctrl_pkg.sv
// Shared definitions for the step/run clock-enable controller: state
// encodings and the default debounce interval.
package step_run_ctrl_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_RUN   = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = MODE_IDLE,
        ST_STEP  = MODE_STEP,
        ST_RUN   = MODE_RUN,
        ST_BURST = MODE_BURST
    } state_e;

    // At a 50 MHz clock this is 1 ms of stable input before a level is accepted.
    localparam logic [15:0] DEB_CYCLES_DEFAULT = 16'd50000;

endpackage

// File: rtl/pb_debounce.sv
// Input conditioner for one raw switch or pushbutton: a two-flop
// synchroniser, a stability counter that accepts a new level only after
// DEB_CYCLES consecutive differing samples, and a one-cycle rising-edge pulse
// that is aligned with the cycle the accepted level first reads high.
module pb_debounce
    import step_run_ctrl_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        level_d;
    logic        rise_q;
    logic        rise_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Two-flop synchroniser bringing the asynchronous raw input into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (({1'b0, cnt_q} + 17'd1) >= {1'b0, DEB_CYCLES}) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/step_run_ctrl.sv
// Single scheduler for the datapath clock-enable. Arbitrates between a
// single-step button, a free-run switch and a burst button; RUN and BURST
// share one prescaler so pulse spacing is div+1 cycles in both.
module step_run_ctrl
    import step_run_ctrl_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int          DIV_W      = 16,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stepPb,
    input  logic             runSw,
    input  logic             burstPb,
    input  logic [7:0]       burstLen,
    input  logic [DIV_W-1:0] div,
    output logic             clkEn,
    output logic             busy,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] pulseCnt
);

    logic stepRise;
    logic burstRise;
    logic runLevel;
    logic runRise_unused;
    logic stepLevel_unused;
    logic burstLevel_unused;

    state_e           state_q;
    state_e           state_d;
    logic             clkEn_q;
    logic             clkEn_d;
    logic [DIV_W-1:0] psc_q;
    logic [DIV_W-1:0] psc_d;
    logic [DIV_W-1:0] divEff_q;
    logic [DIV_W-1:0] divEff_d;
    logic [7:0]       rem_q;
    logic [7:0]       rem_d;
    logic [CNT_W-1:0] pulseCnt_q;
    logic             pscWrap;
    logic [DIV_W-1:0] pscNext;

    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) uStepDeb (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (stepPb),
        .level_o (stepLevel_unused),
        .rise_o  (stepRise)
    );

    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) uRunDeb (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (runSw),
        .level_o (runLevel),
        .rise_o  (runRise_unused)
    );

    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) uBurstDeb (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (burstPb),
        .level_o (burstLevel_unused),
        .rise_o  (burstRise)
    );

    // Next-state, prescaler and pulse decision; divEff holds the divisor until the next prescaler wrap.
    always_comb begin
        state_d  = state_q;
        clkEn_d  = 1'b0;
        psc_d    = psc_q;
        divEff_d = divEff_q;
        rem_d    = rem_q;
        pscWrap  = (psc_q >= divEff_q);
        pscNext  = pscWrap ? '0 : (psc_q + DIV_W'(1));

        unique case (state_q)
            ST_IDLE: begin
                psc_d = '0;
                if (runLevel) begin
                    state_d  = ST_RUN;
                    clkEn_d  = 1'b1;
                    divEff_d = div;
                end else if (burstRise) begin
                    state_d  = ST_BURST;
                    divEff_d = div;
                    if (burstLen == 8'd0) begin
                        rem_d = 8'd0;
                    end else begin
                        clkEn_d = 1'b1;
                        rem_d   = burstLen - 8'd1;
                    end
                end else if (stepRise) begin
                    state_d = ST_STEP;
                    clkEn_d = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (!runLevel) begin
                    state_d = ST_IDLE;
                    psc_d   = '0;
                end else begin
                    psc_d = pscNext;
                    if (pscWrap) begin
                        clkEn_d  = 1'b1;
                        divEff_d = div;
                    end
                end
            end
            ST_BURST: begin
                if (rem_q == 8'd0) begin
                    state_d = ST_IDLE;
                    psc_d   = '0;
                end else begin
                    psc_d = pscNext;
                    if (pscWrap) begin
                        clkEn_d  = 1'b1;
                        rem_d    = rem_q - 8'd1;
                        divEff_d = div;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, prescaler and burst-remaining registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            clkEn_q  <= 1'b0;
            psc_q    <= '0;
            divEff_q <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            clkEn_q  <= clkEn_d;
            psc_q    <= psc_d;
            divEff_q <= divEff_d;
            rem_q    <= rem_d;
        end
    end

    // Running count of issued enables, wrapping naturally at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulseCnt_q <= '0;
        end else if (clkEn_q) begin
            pulseCnt_q <= pulseCnt_q + CNT_W'(1);
        end
    end

    assign clkEn    = clkEn_q;
    assign mode     = state_q;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_BURST);
    assign pulseCnt = pulseCnt_q;

endmodule

// File: tb/tb_step_run_ctrl.sv
// Directed testbench for step_run_ctrl with a short debounce interval.
module tb_step_run_ctrl;

    localparam logic [1:0] M_IDLE  = 2'b00;
    localparam logic [1:0] M_RUN   = 2'b10;
    localparam logic [1:0] M_BURST = 2'b11;

    logic        clk;
    logic        rst;
    logic        stepPb;
    logic        runSw;
    logic        burstPb;
    logic [7:0]  burstLen;
    logic [15:0] div;
    logic        clkEn;
    logic        busy;
    logic [1:0]  mode;
    logic [15:0] pulseCnt;

    int tests;
    int fails;

    step_run_ctrl #(
        .DEB_CYCLES (16'd4),
        .DIV_W      (16),
        .CNT_W      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stepPb   (stepPb),
        .runSw    (runSw),
        .burstPb  (burstPb),
        .burstLen (burstLen),
        .div      (div),
        .clkEn    (clkEn),
        .busy     (busy),
        .mode     (mode),
        .pulseCnt (pulseCnt)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion before it");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; stepPb = 1'b0; runSw = 1'b0; burstPb = 1'b0;
        burstLen = 8'd0; div = 16'd0;
        repeat (3) tick();
        tests++; if (clkEn !== 1'b0) begin fails++; $display("[TB] FAIL reset_clkEn: got %0b expected 0", clkEn); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        tests++; if (mode !== M_IDLE) begin fails++; $display("[TB] FAIL reset_mode: got %0d expected %0d", mode, M_IDLE); end
        tests++; if (pulseCnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_pulseCnt: got %0d expected 0", pulseCnt); end
        rst = 1'b0;
        repeat (3) tick();
        tests++; if (mode !== M_IDLE) begin fails++; $display("[TB] FAIL post_reset_mode: got %0d expected %0d", mode, M_IDLE); end
    endtask

    task automatic test_step;
        int pulses;
        int firstAt;
        pulses = 0; firstAt = -1;
        stepPb = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (clkEn === 1'b1) begin
                pulses++;
                if (firstAt < 0) firstAt = i;
            end
        end
        tests++; if (pulses != 1) begin fails++; $display("[TB] FAIL step_pulses: got %0d expected 1", pulses); end
        tests++; if (firstAt != 7) begin fails++; $display("[TB] FAIL step_latency: got %0d expected 7", firstAt); end
        tests++; if (pulseCnt !== 16'd1) begin fails++; $display("[TB] FAIL step_pulseCnt1: got %0d expected 1", pulseCnt); end
        stepPb = 1'b0;
        repeat (10) tick();
        pulses = 0;
        stepPb = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (clkEn === 1'b1) pulses++;
        end
        tests++; if (pulses != 1) begin fails++; $display("[TB] FAIL step_repress_pulses: got %0d expected 1", pulses); end
        tests++; if (pulseCnt !== 16'd2) begin fails++; $display("[TB] FAIL step_pulseCnt2: got %0d expected 2", pulseCnt); end
        stepPb = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_bounce;
        int pulses;
        int nonIdle;
        pulses = 0; nonIdle = 0;
        for (int i = 0; i < 20; i++) begin
            stepPb = ((i / 2) % 2) == 0;
            tick();
            if (clkEn === 1'b1) pulses++;
            if (mode !== M_IDLE) nonIdle++;
        end
        stepPb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (clkEn === 1'b1) pulses++;
            if (mode !== M_IDLE) nonIdle++;
        end
        tests++; if (pulses != 0) begin fails++; $display("[TB] FAIL bounce_pulses: got %0d expected 0", pulses); end
        tests++; if (nonIdle != 0) begin fails++; $display("[TB] FAIL bounce_mode: got %0d non-idle cycles expected 0", nonIdle); end
        tests++; if (pulseCnt !== 16'd2) begin fails++; $display("[TB] FAIL bounce_pulseCnt: got %0d expected 2", pulseCnt); end
    endtask

    task automatic test_run;
        logic       expEn;
        logic [1:0] expMode;
        div = 16'd2;
        runSw = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        tests++; if (mode !== M_IDLE) begin fails++; $display("[TB] FAIL run_pre_mode: got %0d expected %0d", mode, M_IDLE); end
        for (int i = 7; i <= 36; i++) begin
            tick();
            expEn = ((i - 7) % 3) == 0;
            tests++; if (clkEn !== expEn) begin fails++; $display("[TB] FAIL run_div2_clkEn cycle %0d: got %0b expected %0b", i, clkEn, expEn); end
            tests++; if (mode !== M_RUN) begin fails++; $display("[TB] FAIL run_div2_mode cycle %0d: got %0d expected %0d", i, mode, M_RUN); end
            if (i == 7) begin
                tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL run_busy: got %0b expected 1", busy); end
            end
        end
        runSw = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j <= 6) begin
                expEn   = ((29 + j) % 3) == 0;
                expMode = M_RUN;
            end else begin
                expEn   = 1'b0;
                expMode = M_IDLE;
            end
            tests++; if (clkEn !== expEn) begin fails++; $display("[TB] FAIL run_stop_clkEn cycle %0d: got %0b expected %0b", j, clkEn, expEn); end
            tests++; if (mode !== expMode) begin fails++; $display("[TB] FAIL run_stop_mode cycle %0d: got %0d expected %0d", j, mode, expMode); end
        end
        div = 16'd0;
        repeat (4) tick();
        runSw = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        for (int i = 7; i <= 16; i++) begin
            tick();
            tests++; if (clkEn !== 1'b1) begin fails++; $display("[TB] FAIL run_div0_clkEn cycle %0d: got %0b expected 1", i, clkEn); end
        end
        runSw = 1'b0;
        repeat (12) tick();
        tests++; if (mode !== M_IDLE) begin fails++; $display("[TB] FAIL run_div0_exit_mode: got %0d expected %0d", mode, M_IDLE); end
        tests++; if (clkEn !== 1'b0) begin fails++; $display("[TB] FAIL run_div0_exit_clkEn: got %0b expected 0", clkEn); end
    endtask

    task automatic test_burst;
        int         pulses;
        logic       expEn;
        logic [1:0] expMode;
        div = 16'd1;
        burstLen = 8'd5;
        burstPb = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 7) stepPb = 1'b1;
            if (i >= 7 && i <= 15) begin
                expEn   = ((i - 7) % 2) == 0;
                expMode = M_BURST;
            end else begin
                expEn   = 1'b0;
                expMode = M_IDLE;
            end
            if (clkEn === 1'b1) pulses++;
            tests++; if (clkEn !== expEn) begin fails++; $display("[TB] FAIL burst5_clkEn cycle %0d: got %0b expected %0b", i, clkEn, expEn); end
            tests++; if (mode !== expMode) begin fails++; $display("[TB] FAIL burst5_mode cycle %0d: got %0d expected %0d", i, mode, expMode); end
        end
        tests++; if (pulses != 5) begin fails++; $display("[TB] FAIL burst5_pulses: got %0d expected 5", pulses); end
        burstPb = 1'b0;
        stepPb = 1'b0;
        repeat (10) tick();
        burstLen = 8'd0;
        burstPb = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            expMode = (i == 7) ? M_BURST : M_IDLE;
            if (clkEn === 1'b1) pulses++;
            tests++; if (mode !== expMode) begin fails++; $display("[TB] FAIL burst0_mode cycle %0d: got %0d expected %0d", i, mode, expMode); end
        end
        tests++; if (pulses != 0) begin fails++; $display("[TB] FAIL burst0_pulses: got %0d expected 0", pulses); end
        burstPb = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_priority;
        int sawBurst;
        div = 16'd1;
        burstLen = 8'd5;
        runSw = 1'b1;
        burstPb = 1'b1;
        for (int i = 1; i <= 7; i++) tick();
        tests++; if (mode !== M_RUN) begin fails++; $display("[TB] FAIL prio_mode: got %0d expected %0d", mode, M_RUN); end
        tests++; if (clkEn !== 1'b1) begin fails++; $display("[TB] FAIL prio_clkEn: got %0b expected 1", clkEn); end
        runSw = 1'b0;
        sawBurst = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (mode === M_BURST) sawBurst++;
        end
        tests++; if (sawBurst != 0) begin fails++; $display("[TB] FAIL prio_burst_dropped: got %0d burst cycles expected 0", sawBurst); end
        tests++; if (mode !== M_IDLE) begin fails++; $display("[TB] FAIL prio_exit_mode: got %0d expected %0d", mode, M_IDLE); end
        burstPb = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_burst;
        int pulses;
        div = 16'd1;
        burstLen = 8'd5;
        burstPb = 1'b1;
        for (int i = 1; i <= 9; i++) tick();
        tests++; if (mode !== M_BURST || clkEn !== 1'b1) begin fails++; $display("[TB] FAIL midburst_second_pulse: got mode %0d clkEn %0b expected mode %0d clkEn 1", mode, clkEn, M_BURST); end
        rst = 1'b1;
        burstPb = 1'b0;
        tick();
        tests++; if (clkEn !== 1'b0) begin fails++; $display("[TB] FAIL midburst_rst_clkEn: got %0b expected 0", clkEn); end
        tests++; if (mode !== M_IDLE) begin fails++; $display("[TB] FAIL midburst_rst_mode: got %0d expected %0d", mode, M_IDLE); end
        tests++; if (pulseCnt !== 16'd0) begin fails++; $display("[TB] FAIL midburst_rst_pulseCnt: got %0d expected 0", pulseCnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midburst_rst_busy: got %0b expected 0", busy); end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (clkEn === 1'b1) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("[TB] FAIL midburst_residual_pulses: got %0d expected 0", pulses); end
        tests++; if (mode !== M_IDLE) begin fails++; $display("[TB] FAIL midburst_after_mode: got %0d expected %0d", mode, M_IDLE); end
    endtask

    task automatic test_wrap;
        int pulses;
        force dut.pulseCnt_q = 16'hFFFF;
        tick();
        release dut.pulseCnt_q;
        tick();
        tests++; if (pulseCnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL wrap_preload: got %h expected ffff", pulseCnt); end
        stepPb = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (clkEn === 1'b1) pulses++;
        end
        tests++; if (pulses != 1) begin fails++; $display("[TB] FAIL wrap_pulses: got %0d expected 1", pulses); end
        tests++; if (pulseCnt !== 16'h0000) begin fails++; $display("[TB] FAIL wrap_pulseCnt: got %h expected 0000", pulseCnt); end
        stepPb = 1'b0;
        repeat (10) tick();
    endtask

    // Scenario sequence.
    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_step();
        test_bounce();
        test_run();
        test_burst();
        test_priority();
        test_reset_mid_burst();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
